gmsk_burst_sequencer: RTL and testbench

GMSK_BURST_SEQUENCER -- requirements
Module: gmsk_burst_sequencer

---
 rtl/gmsk_burst_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_gmsk_burst_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmsk_burst_sequencer.sv
// -----------------------------------------------------------------------------
// gmsk_burst_sequencer
//
// Sequences one GSM normal burst per accepted request into a serial bit stream
// for a GMSK modulator. A free-running symbol counter produces sym_strobe once
// every CLKS_PER_SYMBOL clocks. Every burst symbol is launched on a strobe and
// is held on tx_bit for exactly one symbol period.
//
// Burst layout, in symbols:
//   TAIL0 (3) | DATA0 (58) | TSC (26) | DATA1 (58) | TAIL1 (3) | GUARD
//
// Parameters
//   CLKS_PER_SYMBOL  clocks per symbol (>= 4)
//   GUARD_SYMBOLS    trailing guard symbols (1..15)
//
// Optional feature (compile-time macro)
//   GMSK_BURST_DIFF_ENCODE_EN  differentially encode burst symbols,
//                              tx = b[n] ^ b[n-1], history preset to 1 on accept
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset
//   start_valid  burst request
//   start_ready  high only while idle; handshake latches tsc
//   tsc          training-sequence code (0..7)
//   data_bit     payload bit
//   data_valid   data_bit is valid
//   data_ready   pulses on the strobe that consumes data_bit
//   tx_bit       registered bit to the modulator (1 between bursts)
//   tx_active    high for every burst symbol, guard included
//   sym_strobe   one-cycle pulse at each symbol boundary
//   underrun     sticky: a payload slot found data_valid low
// -----------------------------------------------------------------------------
module gmsk_burst_sequencer #(
  parameter int CLKS_PER_SYMBOL = 124,
  parameter int GUARD_SYMBOLS   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [2:0] tsc,
  input  logic       data_bit,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_bit,
  output logic       tx_active,
  output logic       sym_strobe,
  output logic       underrun
);

  localparam int               CNT_W      = $clog2(CLKS_PER_SYMBOL);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLKS_PER_SYMBOL - 1);
  localparam logic [5:0]       GUARD_LAST = 6'(GUARD_SYMBOLS - 1);

  typedef enum logic [2:0] {
    IDLE, ARMED, TAIL0, DATA0, TSC, DATA1, TAIL1, GUARD
  } state_t;

  // Normal-burst training sequences, 26 bits each, transmitted MSB first.
  function automatic logic [25:0] tsc_lookup(input logic [2:0] code);
    case (code)
      3'd0:    return 26'h0970897;
      3'd1:    return 26'h0B778B7;
      3'd2:    return 26'h10EE90E;
      3'd3:    return 26'h11ED11E;
      3'd4:    return 26'h06B906B;
      3'd5:    return 26'h13AC13A;
      3'd6:    return 26'h29F629F;
      default: return 26'h3BC4BBC;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sym_cnt;
  logic [5:0]       seg_idx, seg_idx_nxt, seg_last;
  logic [2:0]       tsc_q;
  logic [25:0]      tsc_word;
  logic [4:0]       tsc_sel;
  logic             accept, launch, data_slot, seq_bit, out_bit;

  assign sym_strobe  = (sym_cnt == CNT_MAX);
  assign start_ready = (state == IDLE);
  assign accept      = start_valid && start_ready;
  assign tx_active   = !(state inside {IDLE, ARMED});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and process order cannot change behaviour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           sym_cnt <= '0;
    else if (sym_strobe) sym_cnt <= '0;
    else                 sym_cnt <= sym_cnt + 1'b1;
  end

  // Index of the last symbol in the current segment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    seg_last = '0;
    case (state)
      TAIL0, TAIL1: seg_last = 6'd2;
      DATA0, DATA1: seg_last = 6'd57;
      TSC:          seg_last = 6'd25;
      GUARD:        seg_last = GUARD_LAST;
      default:      seg_last = '0;
    endcase
  end

  // state/seg_idx always name the symbol currently on tx_bit; state_nxt and
  // seg_idx_nxt name the symbol launched at this strobe.
  always_comb begin
    state_nxt   = state;
    seg_idx_nxt = seg_idx;
    case (state)
      IDLE:  if (start_valid) state_nxt = ARMED;
      ARMED: if (sym_strobe) begin
        state_nxt   = TAIL0;
        seg_idx_nxt = '0;
      end
      default: if (sym_strobe) begin
        if (seg_idx == seg_last) begin
          seg_idx_nxt = '0;
          case (state)
            TAIL0:   state_nxt = DATA0;
            DATA0:   state_nxt = TSC;
            TSC:     state_nxt = DATA1;
            DATA1:   state_nxt = TAIL1;
            TAIL1:   state_nxt = GUARD;
            default: state_nxt = IDLE;
          endcase
        end else begin
          seg_idx_nxt = seg_idx + 6'd1;
        end
      end
    endcase
  end

  // A launch is a strobe that starts a burst symbol. Payload is consumed on
  // the strobe that launches a DATA0/DATA1 symbol, so data_ready and the new
  // tx_bit line up with the same edge.
  assign launch     = sym_strobe && !(state_nxt inside {IDLE, ARMED});
  assign data_slot  = launch && (state_nxt inside {DATA0, DATA1});
  assign data_ready = data_slot && data_valid;
  assign tsc_word   = tsc_lookup(tsc_q);
  assign tsc_sel    = 5'd25 - seg_idx_nxt[4:0];

  always_comb begin
    seq_bit = 1'b1;
    case (state_nxt)
      TAIL0, TAIL1: seq_bit = 1'b0;
      DATA0, DATA1: seq_bit = data_valid && data_bit;  // underrun sends 0
      TSC:          seq_bit = tsc_word[tsc_sel];
      default:      seq_bit = 1'b1;
    endcase
  end

`ifdef GMSK_BURST_DIFF_ENCODE_EN
  logic diff_hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       diff_hist <= 1'b1;
    else if (accept) diff_hist <= 1'b1;
    else if (launch) diff_hist <= seq_bit;
  end

  assign out_bit = launch ? (seq_bit ^ diff_hist) : 1'b1;
`else
  assign out_bit = launch ? seq_bit : 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      seg_idx  <= '0;
      tsc_q    <= '0;
      tx_bit   <= 1'b1;
      underrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      seg_idx <= seg_idx_nxt;
      if (accept)     tsc_q  <= tsc;
      if (sym_strobe) tx_bit <= out_bit;
      if (accept)                        underrun <= 1'b0;
      else if (data_slot && !data_valid) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gmsk_burst_sequencer
//
// Randomised bench for gmsk_burst_sequencer. A timeline model derives every
// output from the burst schedule (acceptance period, launch strobe, symbol
// number) and is compared against the DUT on every negative clock edge.
// Literal expectations for a known burst pin the model itself.
// -----------------------------------------------------------------------------
module tb_gmsk_burst_sequencer;

  localparam int C = 124;
  localparam int G = 8;
  localparam int N = 148 + G;
  localparam int BURST_CYCLES = 156 * 124;
  localparam int TIMEOUT = 25000;

  logic       clock, reset;
  logic       start_valid, start_ready;
  logic [2:0] tsc;
  logic       data_bit, data_valid, data_ready;
  logic       tx_bit, tx_active, sym_strobe, underrun;

  gmsk_burst_sequencer #(.CLKS_PER_SYMBOL(C), .GUARD_SYMBOLS(G)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .tsc        (tsc),
    .data_bit   (data_bit),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_bit     (tx_bit),
    .tx_active  (tx_active),
    .sym_strobe (sym_strobe),
    .underrun   (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [25:0] tsc_table(input logic [2:0] code);
    case (code)
      3'd0:    return 26'h0970897;
      3'd1:    return 26'h0B778B7;
      3'd2:    return 26'h10EE90E;
      3'd3:    return 26'h11ED11E;
      3'd4:    return 26'h06B906B;
      3'd5:    return 26'h13AC13A;
      3'd6:    return 26'h29F629F;
      default: return 26'h3BC4BBC;
    endcase
  endfunction

  function automatic bit is_payload(input int j);
    return (j >= 3 && j <= 60) || (j >= 87 && j <= 144);
  endfunction

  // ---------------- timeline model -----------------
  int   n = 0;                 // clock periods since reset release
  int   acc_n, p_n, e_n;       // acceptance, launch strobe, final strobe
  bit   burst_on = 1'b0;
  int   mbn = 0;               // bursts accepted so far
  bit   und_m = 1'b0;
  bit   prev_m = 1'b1;
  logic [2:0] tsc_m;
  bit   seq [0:255];

  // ---------------- DUT observations -----------------
  int bn = -1;
  int hs_at [4];
  int dr_cnt [4];
  int act_cnt [4];
  int last_act [4];
  int first_act [4];
  bit sym [4][256];
  int strobe_cnt = 0;
  int first_strobe = -1;
  int dr_since_reset = 0;
  int drops2 = 0;

  // Compare process variables.
  logic [5:0]  exp_v, got_v;
  logic [25:0] m_word;
  bit   exp_strobe, exp_rdy, exp_act, exp_tx, exp_dr, und_set, raw;
  int   mj, mr, off;

  always @(negedge clock) begin
    if (reset) begin
      check("reset_outputs", {59'd0, tx_bit, tx_active, data_ready, sym_strobe, underrun},
            64'b10000);
      n = 0;
      burst_on = 1'b0;
      und_m = 1'b0;
      strobe_cnt = 0;
      first_strobe = -1;
      dr_since_reset = 0;
    end else begin
      exp_strobe = ((n % C) == C - 1);
      exp_rdy    = !(burst_on && n > acc_n && n <= e_n);
      exp_act    = burst_on && n > p_n && n <= e_n;
      exp_tx     = exp_act ? seq[(n - p_n - 1) / C] : 1'b1;
      exp_dr     = 1'b0;
      und_set    = 1'b0;
      if (burst_on && n >= p_n && n < e_n && ((n - p_n) % C) == 0) begin
        mj = (n - p_n) / C;
        if (mj < 3)        raw = 1'b0;
        else if (is_payload(mj)) begin
          if (data_valid) begin raw = data_bit; exp_dr = 1'b1; end
          else begin raw = 1'b0; und_set = 1'b1; end
        end
        else if (mj < 87) begin m_word = tsc_table(tsc_m); raw = m_word[25 - (mj - 61)]; end
        else if (mj < 148) raw = 1'b0;
        else               raw = 1'b1;
`ifdef GMSK_BURST_DIFF_ENCODE_EN
        seq[mj] = raw ^ prev_m;
        prev_m  = raw;
`else
        seq[mj] = raw;
`endif
      end
      exp_v = {exp_tx, exp_act, exp_rdy, exp_dr, exp_strobe, und_m};
      got_v = {tx_bit, tx_active, start_ready, data_ready, sym_strobe, underrun};
      check($sformatf("period%0d {tx_bit,active,ready,dready,strobe,underrun}", n),
            {58'd0, got_v}, {58'd0, exp_v});

      if (start_valid && exp_rdy) begin
        acc_n    = n;
        mr       = (C - 1) - (n % C);
        p_n      = n + ((mr == 0) ? C : mr);
        e_n      = p_n + N * C;
        burst_on = 1'b1;
        tsc_m    = tsc;
        und_m    = 1'b0;
        prev_m   = 1'b1;
        mbn++;
      end
      if (und_set) und_m = 1'b1;

      // Raw DUT observations for the literal checks in the stimulus.
      if (sym_strobe) begin
        strobe_cnt++;
        if (first_strobe < 0) first_strobe = n;
      end
      if (data_ready) dr_since_reset++;
      if (start_valid && start_ready && bn < 3) begin
        bn++;
        hs_at[bn] = n; dr_cnt[bn] = 0; act_cnt[bn] = 0;
        first_act[bn] = -1; last_act[bn] = -1;
      end
      if (bn >= 0) begin
        if (data_ready) dr_cnt[bn]++;
        if (tx_active) begin
          if (first_act[bn] < 0) first_act[bn] = n;
          act_cnt[bn]++;
          last_act[bn] = n;
          off = n - first_act[bn];
          if ((off % C) == C / 2 && off / C < 256) sym[bn][off / C] = tx_bit;
        end
      end
      n++;
    end
  end

  // ---------------- payload driver -----------------
  int drv_j, drv_k;
  bit drv_slot;

  always @(posedge clock) begin
    #1;
    drv_slot = burst_on && n >= p_n && n < e_n && ((n - p_n) % C) == 0;
    drv_j    = drv_slot ? (n - p_n) / C : 0;
    if (drv_slot && is_payload(drv_j)) begin
      drv_k = (drv_j <= 60) ? drv_j - 3 : drv_j - 87 + 58;
      if (mbn == 1) begin
        data_valid = 1'b1;
`ifdef GMSK_BURST_DIFF_ENCODE_EN
        data_bit = 1'b1;
`else
        data_bit = ((drv_k % 2) == 0);
`endif
      end else begin
        data_bit   = 1'($urandom_range(1));
        data_valid = !(drv_k == 10 || $urandom_range(15) == 0);
        if (!data_valid && mbn == 2) drops2++;
      end
    end else begin
      data_valid = 1'($urandom_range(1));
      data_bit   = 1'($urandom_range(1));
    end
  end

  // ---------------- stimulus -----------------
  logic [25:0] pin_tsc;
  logic [7:0]  pin8;
  logic [2:0]  pin3;
  int          waited, target;

  initial begin
    reset = 1'b1; start_valid = 1'b0; tsc = 3'd0;
    data_valid = 1'b0; data_bit = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Idle: strobe cadence and idle outputs.
    repeat (1000) @(posedge clock);
    check("idle_strobe_count", strobe_cnt, 8);
    check("idle_first_strobe", first_strobe, 123);

    // Burst 1: tsc 0, known payload; start_valid held for back-to-back burst 2.
    #1 start_valid = 1'b1; tsc = 3'd0;
    @(posedge clock);
    #1 tsc = 3'($urandom_range(7, 1));

    waited = 0;
    while (bn < 1 && waited < TIMEOUT) begin @(posedge clock); waited++; end
    check("second_accept_seen", bn >= 1, 1);
    #1 start_valid = 1'b0;

    check("b1_data_ready_pulses", dr_cnt[0], 116);
    check("b1_active_cycles", act_cnt[0], BURST_CYCLES);
    check("b2_accept_gap", hs_at[1] - last_act[0], 1);
    pin3 = {sym[0][0], sym[0][1], sym[0][2]};
    pin8 = '0;
    for (int i = 0; i < 8; i++) pin8 = {pin8[6:0], sym[0][3 + i]};
`ifdef GMSK_BURST_DIFF_ENCODE_EN
    check("b1_tail0_bits", pin3, 3'b100);
    check("b1_data0_head", pin8, 8'b1000_0000);
    pin8 = '0;
    for (int i = 0; i < 8; i++) pin8 = {pin8[6:0], sym[0][87 + i]};
    check("b1_data1_head", pin8, 8'b0000_0000);
`else
    check("b1_tail0_bits", pin3, 3'b000);
    check("b1_data0_head", pin8, 8'b1010_1010);
    pin_tsc = '0;
    for (int i = 0; i < 26; i++) pin_tsc = {pin_tsc[24:0], sym[0][61 + i]};
    check("b1_tsc0_bits", pin_tsc, 26'h0970897);
    pin3 = {sym[0][145], sym[0][146], sym[0][147]};
    check("b1_tail1_bits", pin3, 3'b000);
    pin8 = '0;
    for (int i = 0; i < 8; i++) pin8 = {pin8[6:0], sym[0][148 + i]};
    check("b1_guard_bits", pin8, 8'hFF);
`endif

    // Burst 2 runs with random payload and a forced drop at payload symbol 10.
    target = e_n + 3;
    waited = 0;
    while (n < target && waited < TIMEOUT) begin @(posedge clock); #1; waited++; end
    check("b2_end_reached", n >= target, 1);
    check("b2_active_cycles", act_cnt[1], BURST_CYCLES);
    check("b2_data_ready_pulses", dr_cnt[1], 116 - drops2);
    check("b2_underrun_sticky", underrun, 1'b1);
    check("b2_drop_made", drops2 >= 1, 1);

    // Burst 3: reset during symbol 40 of DATA0.
    start_valid = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0;
    @(posedge clock);
    #1;
    target = p_n + 43 * C + 7;
    waited = 0;
    while (n < target && waited < 2 * TIMEOUT) begin @(posedge clock); #1; waited++; end
    check("b3_mid_data0_reached", n >= target, 1);
    check("b3_active_before_reset", tx_active, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_tx_active", tx_active, 1'b0);
    check("reset_tx_bit", tx_bit, 1'b1);
    check("reset_underrun", underrun, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (1000) @(posedge clock);
    #1;
    check("post_reset_start_ready", start_ready, 1'b1);
    check("post_reset_data_ready_pulses", dr_since_reset, 0);
    check("post_reset_tx_active", tx_active, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
